// File: rtl/nukv_fifogen_fwft.sv
// First-word-fall-through stream FIFO: a (DEPTH-1)-entry circular RAM backed by
// a one-entry output register that always holds the oldest word when count > 0.
module nukv_fifogen_fwft #(
  parameter int ADDR_BITS         = 5,
  parameter int DATA_SIZE         = 16,
  parameter int PROG_FULL_THRESH  = 2**ADDR_BITS - 8,
  parameter int PROG_EMPTY_THRESH = 2,
  parameter int PUSH_MODE         = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [DATA_SIZE-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 s_axis_talmostfull,
  output logic [DATA_SIZE-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_talmostempty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow
);

  // Handshake: a word moves on a side only at a rising edge where that side's
  // tvalid and tready are both high; tvalid never waits on tready.
  localparam int DEPTH     = 2**ADDR_BITS;
  localparam int RAM_DEPTH = DEPTH - 1;

  localparam logic [ADDR_BITS:0]   DEPTH_C = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   AFULL_C = (ADDR_BITS+1)'(PROG_FULL_THRESH);
  localparam logic [ADDR_BITS:0]   AEMPT_C = (ADDR_BITS+1)'(PROG_EMPTY_THRESH);
  localparam logic [ADDR_BITS:0]   ONE_C   = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS:0]   TWO_C   = (ADDR_BITS+1)'(2);
  localparam logic [ADDR_BITS-1:0] PTR_END = ADDR_BITS'(RAM_DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

  logic [DATA_SIZE-1:0] mem [RAM_DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count_q;
  logic [ADDR_BITS:0]   count_nxt;
  logic [DATA_SIZE-1:0] out_data_q;
  logic                 overflow_q;

  logic not_full;
  logic head_valid;
  logic ram_empty;
  logic push;
  logic pop;
  logic bypass;
  logic ram_wr;
  logic ram_rd;
  logic drop;

  function automatic logic [ADDR_BITS-1:0] ptr_inc(input logic [ADDR_BITS-1:0] p);
    return (p == PTR_END) ? '0 : p + PTR_ONE;
  endfunction

  // The head register holds one word, so the RAM is empty whenever count <= 1.
  always_comb begin
    not_full   = (count_q != DEPTH_C);
    head_valid = (count_q != '0);
    ram_empty  = (count_q < TWO_C);
    push       = s_axis_tvalid && not_full;
    pop        = head_valid && m_axis_tready;
    bypass     = push && (!head_valid || (pop && ram_empty));
    ram_wr     = push && !bypass;
    ram_rd     = pop && !ram_empty;
    drop       = (PUSH_MODE != 0) && s_axis_tvalid && !not_full;
    count_nxt  = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + ONE_C;
      2'b01:   count_nxt = count_q - ONE_C;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      count_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_nxt;
      if (ram_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (ram_rd) rd_ptr <= ptr_inc(rd_ptr);
      if (bypass)      out_data_q <= s_axis_tdata;
      else if (ram_rd) out_data_q <= mem[rd_ptr];
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (ram_wr && !flush) mem[wr_ptr] <= s_axis_tdata;
  end

  assign s_axis_tready       = not_full || flush;
  assign s_axis_talmostfull  = (count_q >= AFULL_C);
  assign m_axis_tdata        = out_data_q;
  assign m_axis_tvalid       = head_valid;
  assign m_axis_talmostempty = (count_q <= AEMPT_C);
  assign count               = count_q;
  assign overflow            = (PUSH_MODE != 0) ? overflow_q : 1'b0;

endmodule

// File: tb/tb_nukv_fifogen_fwft.sv
// Bench for nukv_fifogen_fwft: strict-mode instance driven against a queue
// scoreboard, plus a push-mode instance for drop/overflow/flush behaviour.
module tb_nukv_fifogen_fwft;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_afull;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_aempty;
  logic [5:0]  count;
  logic        overflow;

  logic        p_flush;
  logic [15:0] p_s_tdata;
  logic        p_s_tvalid;
  logic        p_s_tready;
  logic        p_s_afull;
  logic [15:0] p_m_tdata;
  logic        p_m_tvalid;
  logic        p_m_tready;
  logic        p_m_aempty;
  logic [5:0]  p_count;
  logic        p_overflow;

  int          n_vec;
  int          n_err;
  logic [15:0] exp_q[$];
  logic        hold_valid;
  logic [15:0] hold_data;

  nukv_fifogen_fwft #(.ADDR_BITS(5), .DATA_SIZE(16), .PROG_FULL_THRESH(24),
                      .PROG_EMPTY_THRESH(2), .PUSH_MODE(0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_talmostfull(s_afull),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_talmostempty(m_aempty), .count(count), .overflow(overflow)
  );

  nukv_fifogen_fwft #(.ADDR_BITS(5), .DATA_SIZE(16), .PROG_FULL_THRESH(24),
                      .PROG_EMPTY_THRESH(2), .PUSH_MODE(1)) dut_p (
    .clk(clk), .rst(rst), .flush(p_flush),
    .s_axis_tdata(p_s_tdata), .s_axis_tvalid(p_s_tvalid), .s_axis_tready(p_s_tready),
    .s_axis_talmostfull(p_s_afull),
    .m_axis_tdata(p_m_tdata), .m_axis_tvalid(p_m_tvalid), .m_axis_tready(p_m_tready),
    .m_axis_talmostempty(p_m_aempty), .count(p_count), .overflow(p_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One strict-mode cycle, entered and left at a falling edge. The model
  // decides acceptance from its own occupancy; the DUT ready/valid are checked.
  task automatic step(input logic v, input logic [15:0] d, input logic r);
    int          sz;
    logic [15:0] e;
    sz = exp_q.size();
    if (hold_valid) check("hold", {16'h0, m_tdata}, {16'h0, hold_data});
    check("s_tready", {31'h0, s_tready}, {31'h0, sz < 32});
    check("m_tvalid", {31'h0, m_tvalid}, {31'h0, sz > 0});
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    if (sz > 0 && r) begin
      e = exp_q.pop_front();
      check("data", {16'h0, m_tdata}, {16'h0, e});
    end
    hold_valid = (sz > 0) && !r;
    if (hold_valid) hold_data = exp_q[0];
    if (v && sz < 32) exp_q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    check("count", {26'h0, count}, exp_q.size());
    check("afull", {31'h0, s_afull}, {31'h0, exp_q.size() >= 24});
    check("aempty", {31'h0, m_aempty}, {31'h0, exp_q.size() <= 2});
  endtask

  initial begin
    int words;
    int cyc;
    n_vec = 0; n_err = 0; hold_valid = 1'b0; hold_data = '0;
    rst = 1'b0; flush = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
    p_flush = 1'b0; p_s_tdata = '0; p_s_tvalid = 1'b0; p_m_tready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_count", {26'h0, count}, 0);
    check("rst_tvalid", {31'h0, m_tvalid}, 0);
    check("rst_tdata", {16'h0, m_tdata}, 0);
    check("rst_tready", {31'h0, s_tready}, 1);
    check("rst_afull", {31'h0, s_afull}, 0);
    check("rst_aempty", {31'h0, m_aempty}, 1);
    check("rst_ovf", {31'h0, p_overflow}, 0);
    rst = 1'b1;
    @(negedge clk);

    // single-word fall-through
    step(1'b1, 16'h00A5, 1'b0);
    check("fwft_tvalid", {31'h0, m_tvalid}, 1);
    check("fwft_tdata", {16'h0, m_tdata}, 32'h00A5);
    step(1'b0, 16'h0, 1'b1);

    // fill to full, then a rejected extra write
    for (int i = 0; i < 32; i++) step(1'b1, 16'(i), 1'b0);
    check("full_tready", {31'h0, s_tready}, 0);
    check("full_count", {26'h0, count}, 32);
    step(1'b1, 16'h0BAD, 1'b0);
    check("full_hold_count", {26'h0, count}, 32);
    check("strict_ovf", {31'h0, overflow}, 0);

    // continuous push/pop from full: in order, no bubbles
    for (int i = 0; i < 100; i++) step(1'b1, 16'(16'h1000 + i), 1'b1);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin step(1'b0, 16'h0, 1'b1); cyc++; end
    check("drain1_done", exp_q.size(), 0);

    // random traffic
    words = 0; cyc = 0;
    while (words < 10000 && cyc < 60000) begin
      logic v, r;
      logic [15:0] d;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      if (v && exp_q.size() < 32) words++;
      step(v, d, r);
      cyc++;
    end
    check("rand_words", words, 10000);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin step(1'b0, 16'h0, 1'b1); cyc++; end
    check("drain2_done", exp_q.size(), 0);

    // asynchronous reset mid-stream at count=17
    for (int i = 0; i < 17; i++) step(1'b1, 16'(16'h2000 + i), 1'b0);
    check("pre_rst_count", {26'h0, count}, 17);
    s_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    check("async_count", {26'h0, count}, 0);
    check("async_tvalid", {31'h0, m_tvalid}, 0);
    exp_q.delete();
    hold_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    step(1'b1, 16'hBEEF, 1'b0);
    check("post_rst_tdata", {16'h0, m_tdata}, 32'hBEEF);
    step(1'b0, 16'h0, 1'b1);

    // push mode: fill, drop one, sticky flag, drain order, flush
    p_s_tvalid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      p_s_tdata = 16'(16'h3000 + i);
      @(posedge clk); @(negedge clk);
    end
    check("p_full_count", {26'h0, p_count}, 32);
    check("p_full_tready", {31'h0, p_s_tready}, 0);
    check("p_ovf_clear", {31'h0, p_overflow}, 0);
    p_s_tdata = 16'hDEAD;
    @(posedge clk); @(negedge clk);
    p_s_tvalid = 1'b0;
    check("p_drop_count", {26'h0, p_count}, 32);
    check("p_drop_ovf", {31'h0, p_overflow}, 1);
    check("p_drop_head", {16'h0, p_m_tdata}, 32'h3000);
    @(posedge clk); @(negedge clk);
    check("p_sticky_ovf", {31'h0, p_overflow}, 1);
    p_m_tready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("p_data", {16'h0, p_m_tdata}, 32'h3000 + i);
      @(posedge clk); @(negedge clk);
    end
    p_m_tready = 1'b0;
    check("p_empty_tvalid", {31'h0, p_m_tvalid}, 0);
    check("p_ovf_after_drain", {31'h0, p_overflow}, 1);
    p_s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_s_tdata = 16'(16'h4000 + i);
      @(posedge clk); @(negedge clk);
    end
    p_flush = 1'b1; p_s_tdata = 16'h7777; p_m_tready = 1'b1;
    check("p_flush_tready", {31'h0, p_s_tready}, 1);
    @(posedge clk); @(negedge clk);
    p_flush = 1'b0; p_s_tvalid = 1'b0; p_m_tready = 1'b0;
    check("p_flush_count", {26'h0, p_count}, 0);
    check("p_flush_tvalid", {31'h0, p_m_tvalid}, 0);
    check("p_flush_ovf", {31'h0, p_overflow}, 0);
    p_s_tvalid = 1'b1; p_s_tdata = 16'h5A5A;
    @(posedge clk); @(negedge clk);
    p_s_tvalid = 1'b0;
    check("p_post_flush_tvalid", {31'h0, p_m_tvalid}, 1);
    check("p_post_flush_tdata", {16'h0, p_m_tdata}, 32'h5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
